// File: rtl/hex_word_entry.sv
// rtl/hex_word_entry.sv - switch/button hex digit entry assembled into a word on a valid/ready handshake
// Optional backspace button enabled by defining HEX_ENTRY_BACKSPACE_EN.

module hex_word_entry_debounce #(
    parameter int CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);
    localparam int CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          level;
    logic [CW-1:0] cnt;

    // The press event is the cycle in which the debounced level is about to flip high.
    assign press = sync_b && !level && (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= sync_b;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module hex_word_entry #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int NIBBLES         = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           sw,
    input  logic                 btn_push,
    input  logic                 btn_clr,
`ifdef HEX_ENTRY_BACKSPACE_EN
    input  logic                 btn_back,
`endif
    output logic [4*NIBBLES-1:0] word_out,
    output logic                 word_valid,
    input  logic                 word_ready,
    output logic [3:0]           nib_cnt,
    output logic [15:0]          preview
);
    localparam int W = 4 * NIBBLES;
    localparam logic [3:0] LAST_NIB = 4'(NIBBLES - 1);

    typedef enum logic {COLLECT, FULL} state_t;

    state_t     state;
    logic [3:0] sw_a;
    logic [3:0] sw_b;
    logic       push_evt;
    logic       clr_evt;
    logic       transfer;

    hex_word_entry_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_push (
        .clk(clk), .rst(rst), .raw(btn_push), .press(push_evt)
    );

    hex_word_entry_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
        .clk(clk), .rst(rst), .raw(btn_clr), .press(clr_evt)
    );

`ifdef HEX_ENTRY_BACKSPACE_EN
    logic back_evt;

    hex_word_entry_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_back (
        .clk(clk), .rst(rst), .raw(btn_back), .press(back_evt)
    );
`endif

    assign transfer = (state == FULL) && word_ready;
    assign preview  = word_out[15:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_a       <= 4'h0;
            sw_b       <= 4'h0;
            state      <= COLLECT;
            word_out   <= '0;
            word_valid <= 1'b0;
            nib_cnt    <= 4'd0;
        end else begin
            sw_a <= sw;
            sw_b <= sw_a;
            // Transfer and clear land in the same empty state, so they share one branch.
            if (clr_evt || transfer) begin
                state      <= COLLECT;
                word_out   <= '0;
                word_valid <= 1'b0;
                nib_cnt    <= 4'd0;
`ifdef HEX_ENTRY_BACKSPACE_EN
            end else if (back_evt) begin
                if (state == FULL) begin
                    state      <= COLLECT;
                    word_out   <= {4'h0, word_out[W-1:4]};
                    word_valid <= 1'b0;
                    nib_cnt    <= LAST_NIB;
                end else if (nib_cnt != 4'd0) begin
                    word_out <= {4'h0, word_out[W-1:4]};
                    nib_cnt  <= nib_cnt - 4'd1;
                end
`endif
            end else if (push_evt && (state == COLLECT)) begin
                word_out <= {word_out[W-5:0], sw_b};
                nib_cnt  <= nib_cnt + 4'd1;
                if (nib_cnt == LAST_NIB) begin
                    state      <= FULL;
                    word_valid <= 1'b1;
                end
            end
        end
    end
endmodule
